serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial two's-complement subtractor. Computes diff = a - b, LSB-first, one bit per clock, through a single one-bit full-adder cell with a registered carry.
- Sequential counterpart to the one-bit NAND full adder: it reuses the same per-bit add, run in the subtract direction over time.
- Sits behind a valid/ready operand port and a valid/ready result port. Intended as a small ALU slave for the lab processor datapath.

Parameters:
- WIDTH, 32, operand and result width in bits (legal range 2..64).

Ports:
- clock  input  1  single clock, rising-edge.
- reset  input  1  asynchronous, active-high; returns the block to IDLE.
- in_valid  input  1  operands a/b valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- out_valid  output  1  diff/borrow valid.
- out_ready  input  1  consumer accepts result.
- diff  output  WIDTH  a - b, modulo 2^WIDTH.
- borrow  output  1  1 when a < b (unsigned), i.e. inverted final carry.

Behaviour:
- Reset (async, active-high): state=IDLE; in_ready=1; out_valid=0; diff=0; borrow=0; bit counter=0; carry=0. Operand shift registers are cleared.
- States: IDLE, RUN, DONE. Encoding is 2 bits.
- in_ready is 1 only in IDLE. in_valid outside IDLE is ignored and a/b are not sampled.
- IDLE:
  - When in_valid=1 on a rising edge: latch opA<=a, opB<=~b, carry<=1, count<=0, go to RUN.
- RUN, on each edge:
  - s = opA[0]^opB[0]^carry; carry <= majority(opA[0],opB[0],carry).
  - Result register shifts right with s entering the MSB; opA and opB shift right; count++.
  - When count==WIDTH-1 on the edge, go to DONE.
- Latency: operands accepted on edge k; out_valid=1 from the cycle after edge k+WIDTH. That is WIDTH RUN cycles, then DONE.
- DONE:
  - out_valid=1. diff holds the full result; borrow = ~carry after the final bit.
  - diff and borrow stay stable while out_ready=0 (backpressure, unbounded).
  - When out_ready=1 on an edge: go to IDLE, out_valid drops. diff/borrow keep their last value until the next DONE.
- No overlap: a new operand is accepted at the earliest on the edge after the result handshake, since in_ready only rises in IDLE.
- Boundary cases:
  - a==b: diff=0, borrow=0.
  - b=0: diff=a, borrow=0.
  - a=0, b=1: diff=all-ones, borrow=1.
  - Wrap-around is modulo 2^WIDTH.
- Reset asserted mid-RUN or mid-DONE aborts immediately. The result is discarded and there is no partial out_valid.
- Counter width is clog2(WIDTH)+1, with no overflow possible.

Optional Feature:
- Macro: SERIAL_SUBTRACTOR_OVERFLOW_FLAG_EN.
- Defined:
  - Adds output port overflow, 1 bit, valid with out_valid. It is signed overflow = (carry into MSB) XOR (carry out of MSB).
  - Capture the carry-in on the last RUN cycle in a dedicated flop.
  - Reset value 0; held stable in DONE.
- Undefined: the port and flop are absent; all other behaviour is identical.

Decomposition:
- Shared header (serial_sub_defs.vh):
  - state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - default WIDTH constant.
- One sub-module, serial_sub_bit_cell:
  - a one-bit full adder (sum, carry-out) plus the carry flop, with async reset and a load-carry-to-1 input;
  - instantiated once.
- Top holds the FSM, shift registers, counter and handshake.

Test Plan (WIDTH=8):
- a=8'd5, b=8'd3, out_ready=1 -> out_valid rises exactly 8 cycles after the accept edge; diff=8'h02, borrow=0.
- a=8'd3, b=8'd5 -> diff=8'hFE, borrow=1. With the macro: a=8'h80, b=8'h01 -> diff=8'h7F, overflow=1; a=8'h05, b=8'h03 -> overflow=0.
- Backpressure: a=8'hAA, b=8'h0F, out_ready=0 for 20 cycles -> diff=8'h9B, borrow=0, both held stable; in_ready=0 throughout; one out_ready pulse -> IDLE, in_ready=1 next cycle.
- Pulse reset 4 cycles into RUN -> out_valid=0, in_ready=1, diff=0 immediately. Then a=8'h10, b=8'h01 -> diff=8'h0F.
- While RUN, change a/b and hold in_valid=1 -> result reflects the originally latched operands; no second result until the next IDLE accept.
- Exhaustive: random a/b, 1000 back-to-back transactions with random out_ready stalls -> diff == a-b mod 256 and borrow == (a<b) on every handshake.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg: shared constants for the bit-serial subtractor.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: FSM state encoding (2 bits) and the default operand width.
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_sub_bit_cell.sv
// serial_sub_bit_cell: one-bit full adder with a registered carry.
// Latency: sum/carry-out combinational, carry flop updates on the clock edge.
// Backpressure: none; i_en gates the carry update.
// Ports: clock/reset (async, active-high), i_a/i_b operand bits,
//        i_load forces carry to 1, i_en advances the carry,
//        o_sum/o_cout combinational outputs, o_carry current carry flop.
module serial_sub_bit_cell (
  input  logic clock,
  input  logic reset,
  input  logic i_a,
  input  logic i_b,
  input  logic i_load,
  input  logic i_en,
  output logic o_sum,
  output logic o_cout,
  output logic o_carry
);

  logic r_carry;

  assign o_sum  = i_a ^ i_b ^ r_carry;
  assign o_cout = (i_a & i_b) | (i_a & r_carry) | (i_b & r_carry);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_carry <= 1'b0;
    end else if (i_load) begin
      // Carry-in of 1 plus the inverted subtrahend forms a - b.
      r_carry <= 1'b1;
    end else if (i_en) begin
      r_carry <= o_cout;
    end
  end

  assign o_carry = r_carry;

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial two's-complement a - b, LSB first, one bit per clock.
// Latency: WIDTH clocks from operand accept to out_valid.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE.
// Ports: clock, reset (async, active-high); in_valid/in_ready/a/b operand port;
//        out_valid/out_ready/diff/borrow result port.
// Option: SERIAL_SUBTRACTOR_OVERFLOW_FLAG_EN adds a signed overflow output.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_FLAG_EN
  ,
  output logic             overflow
`endif
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic [WIDTH-2:0] r_shift;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;
  logic [CW-1:0]    r_count;

  logic             w_load;
  logic             w_run;
  logic             w_last;
  logic             w_sum;
  logic             w_cout;
  logic             w_carry;
  logic [WIDTH-1:0] w_shift_nxt;

  assign w_load = (r_state == ST_IDLE) && in_valid;
  assign w_run  = (r_state == ST_RUN);
  assign w_last = w_run && (r_count == CNT_LAST);

  // Previous sums sit below the new bit; on the final bit this is the whole result.
  assign w_shift_nxt = {w_sum, r_shift};

  serial_sub_bit_cell u_bit_cell (
    .clock   (clock),
    .reset   (reset),
    .i_a     (r_op_a[0]),
    .i_b     (r_op_b[0]),
    .i_load  (w_load),
    .i_en    (w_run),
    .o_sum   (w_sum),
    .o_cout  (w_cout),
    .o_carry (w_carry)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_shift     <= '0;
      r_diff      <= '0;
      r_borrow    <= 1'b0;
      r_count     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_op_a     <= a;
            r_op_b     <= ~b;
            r_count    <= '0;
            r_in_ready <= 1'b0;
            r_state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_op_a  <= r_op_a >> 1;
          r_op_b  <= r_op_b >> 1;
          r_shift <= w_shift_nxt[WIDTH-1:1];
          r_count <= r_count + CNT_ONE;
          if (w_last) begin
            // Outputs only change here so they stay put through RUN and IDLE.
            r_diff      <= w_shift_nxt;
            r_borrow    <= ~w_cout;
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign diff      = r_diff;
  assign borrow    = r_borrow;

`ifdef SERIAL_SUBTRACTOR_OVERFLOW_FLAG_EN
  logic r_overflow;

  // On the last bit the carry flop holds the carry into the MSB.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (w_last) begin
      r_overflow <= w_carry ^ w_cout;
    end
  end

  assign overflow = r_overflow;
`else
  // Without the overflow flag the carry into the MSB has no consumer.
  logic w_carry_unused;
  assign w_carry_unused = w_carry;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and randomized checks of serial_subtractor at WIDTH=8.
// Latency: checks out_valid exactly 8 clocks after accept.
// Backpressure: exercises held results under out_ready=0 and random stalls.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clock = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         borrow;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_FLAG_EN
  logic         overflow;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  serial_subtractor #(.WIDTH(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow)
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_FLAG_EN
    ,
    .overflow  (overflow)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    check("accept_wait_timeout", 32'(n >= 50), 0);
    a        = ta;
    b        = tb;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 1;
    while (!out_valid && cyc < 100) begin
      tick();
      cyc++;
    end
    cyc = cyc - 1;
  endtask

  task automatic txn(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                     input logic [W-1:0] exp_d, input logic exp_b);
    int cyc;
    send(ta, tb);
    wait_valid(cyc);
    check({tag, "_latency"}, cyc, 8);
    check({tag, "_diff"}, diff, exp_d);
    check({tag, "_borrow"}, borrow, exp_b);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, out_valid, 0);
    check({tag, "_in_ready"}, in_ready, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int           cyc;
    int           n;
    logic         done;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [W-1:0] ed;

    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    #2 reset  = 1'b1;
    tick();
    tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_diff", diff, 0);
    check("rst_borrow", borrow, 0);
    reset = 1'b0;
    tick();

    // Basic directed vectors and boundary cases.
    txn("sub_5_3", 8'd5, 8'd3, 8'h02, 1'b0);
    txn("sub_3_5", 8'd3, 8'd5, 8'hFE, 1'b1);
    txn("equal", 8'h5A, 8'h5A, 8'h00, 1'b0);
    txn("b_zero", 8'h37, 8'h00, 8'h37, 1'b0);
    txn("zero_minus_one", 8'h00, 8'h01, 8'hFF, 1'b1);
    txn("wrap", 8'h01, 8'hFF, 8'h02, 1'b1);

`ifdef SERIAL_SUBTRACTOR_OVERFLOW_FLAG_EN
    send(8'h80, 8'h01);
    wait_valid(cyc);
    check("ovf_diff", diff, 8'h7F);
    check("ovf_set", overflow, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    send(8'h05, 8'h03);
    wait_valid(cyc);
    check("ovf_clear_diff", diff, 8'h02);
    check("ovf_clear", overflow, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
`endif

    // Backpressure: result held for 20 cycles with out_ready low.
    send(8'hAA, 8'h0F);
    wait_valid(cyc);
    check("bp_latency", cyc, 8);
    for (int i = 0; i < 20; i++) begin
      check("bp_diff", diff, 8'h9B);
      check("bp_borrow", borrow, 0);
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_release_valid", out_valid, 0);
    check("bp_release_in_ready", in_ready, 1);
    check("bp_diff_kept", diff, 8'h9B);

    // Reset four cycles into RUN aborts the operation.
    send(8'h33, 8'h11);
    for (int i = 0; i < 4; i++) tick();
    reset = 1'b1;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_diff", diff, 0);
    check("abort_borrow", borrow, 0);
    tick();
    reset = 1'b0;
    tick();
    txn("after_abort", 8'h10, 8'h01, 8'h0F, 1'b0);

    // Operands changing during RUN with in_valid held must be ignored.
    send(8'h20, 8'h05);
    a        = 8'hFF;
    b        = 8'hFF;
    in_valid = 1'b1;
    wait_valid(cyc);
    check("hold_latency", cyc, 8);
    check("hold_diff", diff, 8'h1B);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_done_diff", diff, 8'h1B);
      check("hold_done_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("hold_release_valid", out_valid, 0);
    for (int i = 0; i < 12; i++) tick();
    check("hold_no_second", out_valid, 0);
    check("hold_idle_ready", in_ready, 1);

    // Random back-to-back transactions with random result stalls.
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      ed = ra - rb;
      send(ra, rb);
      n    = 0;
      done = 1'b0;
      while (!done && n < 200) begin
        out_ready = ($urandom_range(0, 3) != 0);
        if (out_valid && out_ready) begin
          check("rnd_diff", diff, ed);
          check("rnd_borrow", borrow, 32'(ra < rb));
          done = 1'b1;
        end
        tick();
        n++;
      end
      out_ready = 1'b0;
      check("rnd_handshake_timeout", done, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
